// File: rtl/mx11_pkg.sv
// Shared types and constants for the MX11 register bank and its writeback queue.
package mx11_pkg;

   localparam int unsigned REG_COUNT = 16;
   localparam logic [3:0]  FLAGS_IDX = 4'h7;

   localparam logic [3:0]  BANK_REG  = 4'h0;
   localparam logic [3:0]  BANK_EXT  = 4'h1;

   typedef logic [REG_COUNT-1:0][7:0] reg_line_t;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } ext_entry_t;

endpackage

// File: rtl/mx11_wb_fifo.sv
// Bank-1 writeback queue of ext_entry_t.
// MX11_REGBANK_EXT_FIFO_EN defined  : DEPTH-entry circular FIFO.
// MX11_REGBANK_EXT_FIFO_EN undefined: single holding register, DEPTH ignored.
// The caller guarantees i_push only when not full or popping, and i_pop only when valid.
module mx11_wb_fifo
   import mx11_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  ext_entry_t i_entry,
   input  logic       i_pop,
   output ext_entry_t o_head,
   output logic       o_valid,
   output logic       o_full
);

`ifdef MX11_REGBANK_EXT_FIFO_EN
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   ext_entry_t [DEPTH-1:0] r_mem;
   logic [PW-1:0]          r_rd_ptr;
   logic [PW-1:0]          r_wr_ptr;
   logic [CW-1:0]          r_count;

   // Circular buffer; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == CW'(DEPTH));
`else
   ext_entry_t r_entry;
   logic       r_valid;

   // Single holding register; a push alongside a pop simply replaces the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (i_push) begin
         r_entry <= i_entry;
         r_valid <= 1'b1;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_head  = r_entry;
   assign o_valid = r_valid;
   assign o_full  = r_valid;

   // DEPTH has no effect in the single-register build.
   if (DEPTH == 0) begin : g_depth_ignored
   end
`endif

endmodule

// File: rtl/mx11_regbank.sv
// MX11 architectural register bank and writeback sink.
// Bank 0 writes land in the register array; bank 1 writes go to the external queue.
// Optional macro MX11_REGBANK_EXT_FIFO_EN turns the bank-1 queue into an EXT_DEPTH FIFO.
module mx11_regbank
   import mx11_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned EXT_DEPTH   = 2,
   parameter logic [7:0]  FLAGS_RESET = 8'h00
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0][7:0] data_line,
   input  logic [7:0]       load_addr,
   input  logic             we,
   output logic [15:0][7:0] reg_line,
   output logic             ext_valid,
   input  logic             ext_ready,
   output logic [3:0]       ext_addr,
   output logic [7:0]       ext_data,
   output logic             busy,
   output logic             ovf
);

   logic [$clog2(DEPTH)-1:0] w_idx;
   logic [3:0]               w_bank;
   logic [DATA_WIDTH-1:0]    w_wdata;
   logic                     w_wr_reg;
   logic                     w_wr_ext;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_full;
   ext_entry_t               w_entry;
   ext_entry_t               w_head;
   reg_line_t                r_regs;
   logic                     r_ovf;

   assign w_idx    = load_addr[3:0];
   assign w_bank   = load_addr[7:4];
   assign w_wdata  = data_line[w_idx];
   assign w_wr_reg = we && (w_bank == BANK_REG);
   assign w_wr_ext = we && (w_bank == BANK_EXT);

   assign w_pop    = ext_valid && ext_ready;
   assign busy     = w_full && !w_pop;
   assign w_push   = w_wr_ext && !busy;

   assign w_entry.addr = w_idx;
   assign w_entry.data = w_wdata;

   // Register array: bank-0 writes always accepted, FLAGS stored verbatim.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs            <= '0;
         r_regs[FLAGS_IDX] <= FLAGS_RESET;
      end else if (w_wr_reg) begin
         r_regs[w_idx] <= w_wdata;
      end
   end

   // Sticky overflow: set whenever a bank-1 write is refused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_wr_ext && busy) begin
         r_ovf <= 1'b1;
      end
   end

   mx11_wb_fifo #(
      .DEPTH (EXT_DEPTH)
   ) u_wb_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_valid (ext_valid),
      .o_full  (w_full)
   );

   assign reg_line = r_regs;
   assign ext_addr = w_head.addr;
   assign ext_data = w_head.data;
   assign ovf      = r_ovf;

endmodule
